// File: rtl/arb4way16.sv
// arb4way16: four-channel round-robin arbiter feeding a registered word/select pair.
// Define ARB4WAY16_LOCK_EN to add a `lock` input that lets the last winner keep the grant.
module arb4way16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [WIDTH-1:0] in_C,
    input  logic [WIDTH-1:0] in_D,
    input  logic [3:0]       in_valid,
    output logic [3:0]       in_ready,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       out_sel,
    output logic             out_valid,
`ifdef ARB4WAY16_LOCK_EN
    input  logic             lock,
`endif
    input  logic             out_ready
);

    logic [1:0]       last_grant_q;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       sel_q;
    logic             valid_q;

    logic             load;
    logic             found;
    logic [1:0]       winner;
    logic [1:0]       cand;
    logic [WIDTH-1:0] win_data;

    // The output slot may be refilled when empty or being consumed this cycle.
    assign load = !valid_q || out_ready;

    // Search starts one past the last winner; the 2-bit add wraps 3 -> 0 for free.
    always_comb begin
        found  = 1'b0;
        winner = last_grant_q;
        cand   = last_grant_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant_q + 2'(k);
            if (!found && in_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`ifdef ARB4WAY16_LOCK_EN
        if (lock && in_valid[last_grant_q]) begin
            found  = 1'b1;
            winner = last_grant_q;
        end
`endif
    end

    always_comb begin
        win_data = in_A;
        unique case (winner)
            2'd0: win_data = in_A;
            2'd1: win_data = in_B;
            2'd2: win_data = in_C;
            2'd3: win_data = in_D;
        endcase
    end

    // A cycle with reset high never hands out a grant, since its word would be discarded.
    always_comb begin
        in_ready = 4'b0000;
        if (!reset && load && found) begin
            in_ready = 4'b0001 << winner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q        <= '0;
            sel_q        <= 2'd0;
            valid_q      <= 1'b0;
            last_grant_q <= 2'd3;
        end else if (load) begin
            if (found) begin
                out_q        <= win_data;
                sel_q        <= winner;
                valid_q      <= 1'b1;
                last_grant_q <= winner;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out       = out_q;
    assign out_sel   = sel_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_arb4way16.sv
// Self-checking bench for arb4way16: directed scenarios, then randomized traffic vs. a queue-free model.
module tb_arb4way16;

`ifdef ARB4WAY16_LOCK_EN
    localparam bit LockEn = 1'b1;
`else
    localparam bit LockEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] din [4];
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [15:0] out;
    logic [1:0]  out_sel;
    logic        out_valid;
    logic        out_ready;
    logic        lock_s;

    int tests = 0;
    int fails = 0;

    // Reference state, named after the spec's architectural quantities.
    int          m_last;
    int          m_sel;
    logic [15:0] m_out;
    logic        m_valid;
    logic [3:0]  last_rdy;

    always #5 clk = ~clk;

    arb4way16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_A      (din[0]),
        .in_B      (din[1]),
        .in_C      (din[2]),
        .in_D      (din[3]),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
`ifdef ARB4WAY16_LOCK_EN
        .lock      (lock_s),
`endif
        .out_ready (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Winner by the round-robin rule: first requester after the last grant, wrapping mod 4.
    function automatic int pick(input logic [3:0] v, input int last, input logic lk);
        if (lk && v[last]) return last;
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic cycle();
        int         w;
        logic       ld;
        logic [3:0] er;
        @(negedge clk);
        ld = !m_valid || out_ready;
        w  = pick(in_valid, m_last, LockEn && lock_s);
        er = (!reset && ld && w >= 0) ? 4'(1 << w) : 4'b0000;
        chk("in_ready", 32'(in_ready), 32'(er));
        last_rdy = er;
        @(posedge clk);
        if (reset) begin
            m_out = 16'h0; m_sel = 0; m_valid = 1'b0; m_last = 3;
        end else if (ld) begin
            if (w >= 0) begin
                m_out = din[w]; m_sel = w; m_valid = 1'b1; m_last = w;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("out_sel", 32'(out_sel), 32'(m_sel));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
    endtask

    initial begin
        m_last = 3; m_sel = 0; m_out = 16'h0; m_valid = 1'b0; last_rdy = 4'b0;
        din[0] = 16'h000A; din[1] = 16'h000B; din[2] = 16'h000C; din[3] = 16'h000D;
        lock_s = 1'b0; out_ready = 1'b1; in_valid = 4'b1111;

        // Reset held two cycles with everyone requesting.
        reset = 1'b1;
        cycle();
        cycle();
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;

        // Full contention: A, B, C, D, A, ...
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("contend_sel", 32'(out_sel), 32'(i % 4));
            chk("contend_out", 32'(out), 32'(16'h000A + 16'(i % 4)));
        end
        cycle();
        cycle();
        chk("bp_setup", 32'(out), 32'h000B);

        // Backpressure holds the word and blocks every grant.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_rdy", 32'(last_rdy), 32'h0);
            chk("bp_sel", 32'(out_sel), 32'h1);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_release", 32'(last_rdy), 32'b0100);

        // Lone D request, then idle drains the slot.
        in_valid = 4'b1000; din[3] = 16'h1234;
        cycle();
        chk("sparse_out", 32'(out), 32'h1234);
        chk("sparse_sel", 32'(out_sel), 32'h3);
        in_valid = 4'b0000;
        cycle();
        chk("drain_valid", 32'(out_valid), 32'h0);
        chk("drain_out", 32'(out), 32'h1234);

        // Reset mid-stream at out_sel=2.
        din[3] = 16'h000D; in_valid = 4'b1111;
        for (int i = 0; i < 8 && !(out_valid && out_sel == 2'd2); i++) cycle();
        chk("reach_sel2", 32'(out_sel), 32'h2);
        reset = 1'b1;
        cycle();
        chk("midrst_valid", 32'(out_valid), 32'h0);
        reset = 1'b0;
        cycle();
        chk("midrst_first", 32'(out_sel), 32'h0);

`ifdef ARB4WAY16_LOCK_EN
        in_valid = 4'b0011;
        cycle();
        chk("lock_b", 32'(out_sel), 32'h1);
        lock_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("lock_hold", 32'(out_sel), 32'h1);
        end
        lock_s = 1'b0;
        cycle();
        chk("unlock_a", 32'(out_sel), 32'h0);
        cycle();
        chk("unlock_b", 32'(out_sel), 32'h1);
`endif

        // Randomized traffic; requesters keep data and valid until granted.
        in_valid = 4'b0000;
        last_rdy = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 63) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            lock_s    = ($urandom_range(0, 1) == 1);
            for (int c = 0; c < 4; c++) begin
                if (!(in_valid[c] && !last_rdy[c])) begin
                    in_valid[c] = ($urandom_range(0, 1) == 1);
                    din[c]      = 16'($urandom);
                end
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
